// File: rtl/vtg_pkg.sv
// Shared video timing constants and total-count helper for video_timing_gen.
// Mode records cover 640x480@60, 800x600@60 and 1024x768@60.
package vtg_pkg;

   typedef struct packed {
      logic [15:0] active;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } axis_t;

   typedef struct packed {
      axis_t h;
      axis_t v;
      logic  hs_pol;
      logic  vs_pol;
   } mode_t;

   localparam mode_t MODE_640X480_60 = '{
      h:      '{16'd640, 16'd16, 16'd96, 16'd48},
      v:      '{16'd480, 16'd10, 16'd2, 16'd33},
      hs_pol: 1'b0,
      vs_pol: 1'b0
   };

   localparam mode_t MODE_800X600_60 = '{
      h:      '{16'd800, 16'd40, 16'd128, 16'd88},
      v:      '{16'd600, 16'd1, 16'd4, 16'd23},
      hs_pol: 1'b1,
      vs_pol: 1'b1
   };

   localparam mode_t MODE_1024X768_60 = '{
      h:      '{16'd1024, 16'd24, 16'd136, 16'd160},
      v:      '{16'd768, 16'd3, 16'd6, 16'd29},
      hs_pol: 1'b0,
      vs_pol: 1'b0
   };

   function automatic int unsigned vtg_total(
      input int unsigned active,
      input int unsigned fp,
      input int unsigned sync,
      input int unsigned bp
   );
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vtg_if.sv
// Video bundle between drawing logic and the timing generator.
// master = generator side, slave = drawing/display side.
interface vtg_if #(
   parameter int COLOR_W = 6,
   parameter int CNT_W   = 12
);
   logic [COLOR_W-1:0] r_in;
   logic [COLOR_W-1:0] g_in;
   logic [COLOR_W-1:0] b_in;
   logic [CNT_W-1:0]   hc;
   logic [CNT_W-1:0]   vc;
   logic               hsync;
   logic               vsync;
   logic               blank;
   logic               line_start;
   logic               frame_start;
   logic [COLOR_W-1:0] r;
   logic [COLOR_W-1:0] g;
   logic [COLOR_W-1:0] b;

   modport master (
      input  r_in, g_in, b_in,
      output hc, vc, hsync, vsync, blank,
      output line_start, frame_start,
      output r, g, b
   );

   modport slave (
      output r_in, g_in, b_in,
      input  hc, vc, hsync, vsync, blank,
      input  line_start, frame_start,
      input  r, g, b
   );
endinterface

// File: rtl/vtg_axis_counter.sv
// Single-axis wrapping counter; wrap is a combinational carry to the next axis.
module vtg_axis_counter #(
   parameter int TOTAL = 800,
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

   assign wrap = inc && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (wrap)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/video_timing_gen.sv
// VGA-style timing generator with registered syncs, blank and gated colour.
// Define VTG_TEST_PATTERN_EN to add test_en and an 8-bar colour pattern.
module video_timing_gen
   import vtg_pkg::*;
#(
   parameter int H_ACTIVE = int'(MODE_640X480_60.h.active),
   parameter int H_FP     = int'(MODE_640X480_60.h.fp),
   parameter int H_SYNC   = int'(MODE_640X480_60.h.sync),
   parameter int H_BP     = int'(MODE_640X480_60.h.bp),
   parameter int V_ACTIVE = int'(MODE_640X480_60.v.active),
   parameter int V_FP     = int'(MODE_640X480_60.v.fp),
   parameter int V_SYNC   = int'(MODE_640X480_60.v.sync),
   parameter int V_BP     = int'(MODE_640X480_60.v.bp),
   parameter bit HS_POL   = MODE_640X480_60.hs_pol,
   parameter bit VS_POL   = MODE_640X480_60.vs_pol,
   parameter int COLOR_W  = 6,
   parameter int CNT_W    = 12
) (
   input  logic  clk25m,
   input  logic  rst_n,
   input  logic  enable,
`ifdef VTG_TEST_PATTERN_EN
   input  logic  test_en,
`endif
   vtg_if.master vid
);

   localparam int H_TOTAL = int'(vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int V_TOTAL = int'(vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
      $error("video_timing_gen: timing parameter is zero");
   end

   if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_cnt_too_small
      $error("video_timing_gen: CNT_W too narrow for totals");
   end

   localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [CNT_W-1:0]   hc;
   logic [CNT_W-1:0]   vc;
   logic               h_wrap;
   logic               v_wrap;

   logic               hs_d;
   logic               vs_d;
   logic               blank_d;
   logic               ls_d;
   logic               fs_d;
   logic [COLOR_W-1:0] r_d;
   logic [COLOR_W-1:0] g_d;
   logic [COLOR_W-1:0] b_d;

   logic               hs_q;
   logic               vs_q;
   logic               blank_q;
   logic               ls_q;
   logic               fs_q;
   logic [COLOR_W-1:0] r_q;
   logic [COLOR_W-1:0] g_q;
   logic [COLOR_W-1:0] b_q;

   vtg_axis_counter #(
      .TOTAL (H_TOTAL),
      .CNT_W (CNT_W)
   ) u_hcnt (
      .clk   (clk25m),
      .rst_n (rst_n),
      .inc   (enable),
      .cnt   (hc),
      .wrap  (h_wrap)
   );

   vtg_axis_counter #(
      .TOTAL (V_TOTAL),
      .CNT_W (CNT_W)
   ) u_vcnt (
      .clk   (clk25m),
      .rst_n (rst_n),
      .inc   (h_wrap),
      .cnt   (vc),
      .wrap  (v_wrap)
   );

`ifdef VTG_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic [2:0] bar;
   logic [2:0] bar_rgb;

   always_comb begin
      bar = '0;
      for (int k = 1; k < 8; k++) begin
         if (hc >= CNT_W'(k * BAR_W))
            bar = bar + 3'd1;
      end
   end

   // Bar order white..black maps onto inverted index bits.
   assign bar_rgb = {~bar[1], ~bar[2], ~bar[0]};
`endif

   always_comb begin
      hs_d    = (hc >= HS_BEG && hc <= HS_END) ? HS_POL : ~HS_POL;
      vs_d    = (vc >= VS_BEG && vc <= VS_END) ? VS_POL : ~VS_POL;
      blank_d = (hc >= HA) || (vc >= VA);
      ls_d    = (hc == '0);
      fs_d    = (hc == '0) && (vc == '0);
      r_d     = vid.r_in;
      g_d     = vid.g_in;
      b_d     = vid.b_in;
`ifdef VTG_TEST_PATTERN_EN
      if (test_en) begin
         r_d = {COLOR_W{bar_rgb[2]}};
         g_d = {COLOR_W{bar_rgb[1]}};
         b_d = {COLOR_W{bar_rgb[0]}};
      end
`endif
      if (blank_d) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end
   end

   always_ff @(posedge clk25m or negedge rst_n) begin
      if (!rst_n) begin
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         blank_q <= 1'b1;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else if (enable) begin
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end
   end

   assign vid.hc          = hc;
   assign vid.vc          = vc;
   assign vid.hsync       = hs_q;
   assign vid.vsync       = vs_q;
   assign vid.blank       = blank_q;
   assign vid.line_start  = ls_q;
   assign vid.frame_start = fs_q;
   assign vid.r           = r_q;
   assign vid.g           = g_q;
   assign vid.b           = b_q;

   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, HS_POL 0, VS_POL 0, COLOR_W 6, CNT_W 12.
REQ-002 SHALL have ports:
- clk25m  in  1  pixel clock; one clock only
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  counters advance when high
- r_in, g_in, b_in  in  COLOR_W  pixel colour from drawing logic
- hc, vc  out  CNT_W  current horizontal and vertical count
- hsync, vsync  out  1  syncs at HS_POL / VS_POL polarity
- blank  out  1  high outside the active area
- line_start, frame_start  out  1  one-cycle pulses
- r, g, b  out  COLOR_W  blank-gated, sync-aligned colour

Function
REQ-003 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
REQ-004 SHALL increment hc by one on each enabled cycle, wrapping from H_TOTAL-1 to 0.
REQ-005 SHALL increment vc only on the hc wrap, wrapping from V_TOTAL-1 to 0; simultaneous hc and vc wrap SHALL give hc=0, vc=0.
REQ-006 SHALL hold all counters and registered outputs unchanged while enable=0.
REQ-007 SHALL register hsync, vsync, blank, line_start, frame_start and r/g/b from the hc/vc values of the previous cycle, so these outputs lag hc/vc by exactly 1 cycle.
REQ-008 SHALL assert hsync (HS_POL level) for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise !HS_POL.
REQ-009 SHALL assert vsync (VS_POL level) for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for the whole line.
REQ-010 SHALL drive blank=1 when hc>=H_ACTIVE or vc>=V_ACTIVE.
REQ-011 SHALL drive r/g/b = registered r_in/g_in/b_in when not blanking and 0 when blanking; drawing logic samples hc/vc combinationally in the same cycle.
REQ-012 SHALL pulse line_start for the hc=0 cycle of every line, and frame_start only for the hc=0, vc=0 cycle.
REQ-013 SHALL fail elaboration if H_TOTAL or V_TOTAL exceeds 2**CNT_W or if any timing parameter is 0.

Reset
REQ-014 SHALL, while rst_n=0, force hc=0, vc=0, hsync=!HS_POL, vsync=!VS_POL, blank=1, r/g/b=0, line_start=0, frame_start=0.
REQ-015 SHALL, on the first enabled edge after reset release, register the outputs for hc=0, vc=0; frame_start=1 on that edge. Reset asserted mid-frame SHALL restart from hc=0, vc=0 with no partial pulse.

Configuration
REQ-016 SHALL add input test_en when VTG_TEST_PATTERN_EN is defined. With test_en=1, the active-area colour SHALL be replaced by 8 vertical bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. Each component SHALL be all-ones or 0. Timing and latency SHALL be unchanged.
REQ-017 SHALL omit test_en and the pattern logic when the macro is undefined; r/g/b then follow REQ-011 only.

Structure
REQ-018 SHALL place the mode timing constants (640x480@60, 800x600@60, 1024x768@60) and a total-computation function in shared package vtg_pkg.
REQ-019 SHALL implement the horizontal and vertical counters with two instances of sub-module vtg_axis_counter (count, wrap-out, enable-in, parameterised total).

Verification
REQ-020 Defaults, enable=1, 840000 cycles after reset -> frame_start pulses exactly twice, 420000 cycles apart; line_start every 800 cycles.
REQ-021 Defaults -> hsync=0 exactly on the cycles after hc=656..751; vsync=0 during lines vc=490..491; blank=0 for 640x480 pixels per frame.
REQ-022 r_in=6'h3F, g_in=0, b_in=6'h15 constant -> r/g/b=3F/00/15 in the active area, 00/00/00 in blanking, 1-cycle lag behind hc.
REQ-023 enable low for 100 cycles at hc=300, vc=200 -> hc, vc and all outputs frozen; resume at hc=301.
REQ-024 rst_n pulsed low at vc=250 -> immediate REQ-014 values; frame_start on the first edge after release.
REQ-025 VTG_TEST_PATTERN_EN defined, test_en=1 -> hc=0..79 gives 3F/3F/3F, hc=80..159 gives 3F/3F/00, hc=560..639 gives 00/00/00.
